fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0): bubble instruction placed in IF/ID.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 stall_i  input  1  hazard hold request from decode/hazard logic.
REQ-006 redirect_i  input  1  taken branch/jump; flush and reload PC.
REQ-007 redirect_pc_i  input  32  redirect target address.
REQ-008 imem_addr_o  output  32  instruction memory byte address.
REQ-009 imem_rdata_i  input  32  instruction word, combinational read of imem_addr_o.
REQ-010 ifid_pc_o  output  32  PC of the instruction in IF/ID.
REQ-011 ifid_pc4_o  output  32  ifid_pc_o + 4.
REQ-012 ifid_instr_o  output  32  instruction word in IF/ID.
REQ-013 ifid_valid_o  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-014 fetch_count_o  output  32  count of instructions loaded valid into IF/ID.

Function
REQ-015 imem_addr_o SHALL equal the internal PC register combinationally; no other path drives it.
REQ-016 Normal cycle (redirect_i=0, stall_i=0): PC <= PC+4; IF/ID <= {pc=PC, pc4=PC+4, instr=imem_rdata_i, valid=1}; fetch_count_o += 1.
REQ-017 Stall cycle (redirect_i=0, stall_i=1): PC, all IF/ID fields and fetch_count_o SHALL hold.
REQ-018 Redirect cycle (redirect_i=1): PC <= {redirect_pc_i[31:2],2'b00}; IF/ID <= {pc=0, pc4=0, instr=NOP_INSTR, valid=0}; fetch_count_o holds.
REQ-019 redirect_i SHALL take priority over stall_i when both are asserted in the same cycle.
REQ-020 Redirect target bits [1:0] SHALL be forced to zero; no misalignment exception is raised.
REQ-021 Fetch latency: instruction at address A SHALL appear on ifid_instr_o on the rising edge after imem_addr_o = A with stall_i=0, redirect_i=0.
REQ-022 PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000; no flag or stall.
REQ-023 ifid_pc4_o SHALL be computed with the same 32-bit wrap (pc 32'hFFFF_FFFC gives pc4 32'h0).
REQ-024 fetch_count_o SHALL wrap 32'hFFFF_FFFF -> 0 silently.
REQ-025 imem_rdata_i SHALL be sampled only in normal cycles; its value during stall or redirect has no effect.
REQ-026 No internal state other than PC, IF/ID register and fetch counter; no FSM beyond the normal/stall/redirect priority decode.

Reset
REQ-027 rst_n=0 SHALL immediately (asynchronously) set PC=RESET_PC, ifid_pc_o=0, ifid_pc4_o=0, ifid_instr_o=NOP_INSTR, ifid_valid_o=0, fetch_count_o=0.
REQ-028 While rst_n=0, state SHALL hold reset values regardless of clk, stall_i and redirect_i.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL discard that operation; first edge after release is an ordinary normal/stall/redirect cycle from PC=RESET_PC.
REQ-030 First edge after release with stall_i=0 SHALL load the word at RESET_PC into IF/ID with valid=1.

Verification
REQ-031 Reset then 4 free-running cycles, imem word = 32'hA000_0000|addr -> ifid_pc_o 0,4,8,12; ifid_instr_o 32'hA000_0000..32'hA000_000C; valid=1; fetch_count_o=4.
REQ-032 Stall 3 cycles while IF/ID holds pc=8 -> IF/ID fields, imem_addr_o=12 and fetch_count_o unchanged for 3 edges; next normal edge loads pc=12.
REQ-033 redirect_i=1, stall_i=1, redirect_pc_i=32'h0000_0103 -> next edge imem_addr_o=32'h100, ifid_valid_o=0, ifid_instr_o=32'h0000_0013; following edge ifid_pc_o=32'h100, valid=1.
REQ-034 Redirect to 32'hFFFF_FFFC then 2 normal cycles -> ifid_pc_o=32'hFFFF_FFFC with ifid_pc4_o=0, then ifid_pc_o=0.
REQ-035 rst_n pulsed low mid-cycle (between edges) during a stall -> outputs reach reset values before the next edge; after release fetch restarts at RESET_PC, fetch_count_o=0.
REQ-036 Preload fetch_count_o to 32'hFFFF_FFFF via force, one normal cycle -> fetch_count_o=0.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage of a simple in-order RISC-V pipeline. Holds the
//   program counter, the IF/ID pipeline register and a count of real
//   instructions handed to decode. Each rising edge is classified as one of:
//     redirect : reload PC with the word-aligned target and bubble IF/ID
//     stall    : hold everything
//     normal   : capture the fetched word into IF/ID and advance PC by 4
//   Redirect has priority over stall.
//
// Ports
//   clk            in   1   clock, rising-edge active
//   rst_n          in   1   asynchronous active-low reset
//   stall_i        in   1   hold request from hazard logic
//   redirect_i     in   1   taken branch/jump, flush and reload PC
//   redirect_pc_i  in   32  redirect target (bits [1:0] ignored)
//   imem_addr_o    out  32  instruction memory byte address (= PC)
//   imem_rdata_i   in   32  instruction word at imem_addr_o (combinational)
//   ifid_pc_o      out  32  PC of the instruction in IF/ID
//   ifid_pc4_o     out  32  ifid_pc_o + 4 (32-bit wrap)
//   ifid_instr_o   out  32  instruction word in IF/ID
//   ifid_valid_o   out  1   IF/ID holds a real instruction (0 = bubble)
//   fetch_count_o  out  32  number of instructions loaded valid into IF/ID
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_valid_o,
    output logic [31:0] fetch_count_o
);

    logic [31:0] pc_r;
    logic [31:0] ifid_pc_r;
    logic [31:0] ifid_pc4_r;
    logic [31:0] ifid_instr_r;
    logic        ifid_valid_r;
    logic [31:0] fetch_count_r;

    logic [31:0] pc_next_s;
    logic [31:0] ifid_pc_next_s;
    logic [31:0] ifid_pc4_next_s;
    logic [31:0] ifid_instr_next_s;
    logic        ifid_valid_next_s;
    logic [31:0] fetch_count_next_s;
    logic [31:0] pc_plus4_s;

    // Sequential PC increment; natural 32-bit overflow gives the required wrap.
    assign pc_plus4_s = pc_r + 32'd4;

    // Priority decode of redirect / stall / normal and next-state values.
    always_comb begin
        pc_next_s          = pc_r;
        ifid_pc_next_s     = ifid_pc_r;
        ifid_pc4_next_s    = ifid_pc4_r;
        ifid_instr_next_s  = ifid_instr_r;
        ifid_valid_next_s  = ifid_valid_r;
        fetch_count_next_s = fetch_count_r;
        if (redirect_i) begin
            // Target is forced word-aligned; the in-flight fetch becomes a bubble
            // and imem_rdata_i is ignored.
            pc_next_s         = {redirect_pc_i[31:2], 2'b00};
            ifid_pc_next_s    = 32'h0000_0000;
            ifid_pc4_next_s   = 32'h0000_0000;
            ifid_instr_next_s = NOP_INSTR;
            ifid_valid_next_s = 1'b0;
        end else if (stall_i) begin
            // Hold: defaults above keep every register unchanged.
            pc_next_s = pc_r;
        end else begin
            pc_next_s          = pc_plus4_s;
            ifid_pc_next_s     = pc_r;
            ifid_pc4_next_s    = pc_plus4_s;
            ifid_instr_next_s  = imem_rdata_i;
            ifid_valid_next_s  = 1'b1;
            fetch_count_next_s = fetch_count_r + 32'd1;
        end
    end

    // PC, IF/ID and fetch counter registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC;
            ifid_pc_r     <= 32'h0000_0000;
            ifid_pc4_r    <= 32'h0000_0000;
            ifid_instr_r  <= NOP_INSTR;
            ifid_valid_r  <= 1'b0;
            fetch_count_r <= 32'h0000_0000;
        end else begin
            pc_r          <= pc_next_s;
            ifid_pc_r     <= ifid_pc_next_s;
            ifid_pc4_r    <= ifid_pc4_next_s;
            ifid_instr_r  <= ifid_instr_next_s;
            ifid_valid_r  <= ifid_valid_next_s;
            fetch_count_r <= fetch_count_next_s;
        end
    end

    assign imem_addr_o   = pc_r;
    assign ifid_pc_o     = ifid_pc_r;
    assign ifid_pc4_o    = ifid_pc4_r;
    assign ifid_instr_o  = ifid_instr_r;
    assign ifid_valid_o  = ifid_valid_r;
    assign fetch_count_o = fetch_count_r;

endmodule
